// File: rtl/multi_ball_pixel_gen.sv
// Two-stage pixel compositor for the multi-ball pong display: header text, walls,
// paddles with hit-flash, up to NUM_BALLS round sprites and background/game-over images.
module multi_ball_pixel_gen #(
  parameter int NUM_BALLS    = 4,
  parameter int TOP_MARGIN   = 25,
  parameter int PADDLE_H     = 72,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     video_on,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     frame_tick,
  input  logic                     text_on,
  input  logic [11:0]              text_rgb,
  input  logic [11:0]              bg_pixel,
  input  logic [11:0]              game_over_pixel,
  input  logic                     game_over,
  input  logic [9:0]               paddle1_y,
  input  logic [9:0]               paddle2_y,
  input  logic [10*NUM_BALLS-1:0]  ball_x,
  input  logic [10*NUM_BALLS-1:0]  ball_y,
  input  logic [4*NUM_BALLS-1:0]   ball_speed,
  input  logic [NUM_BALLS-1:0]     ball_en,
  input  logic                     hit_l,
  input  logic                     hit_r,
  output logic [11:0]              rgb
);
  localparam int          IDX_W      = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [3:0]  FLASH_LOAD = 4'(FLASH_FRAMES);
  localparam logic [10:0] TOP_M      = 11'(TOP_MARGIN);
  localparam logic [10:0] PAD_H      = 11'(PADDLE_H);

  function automatic logic [7:0] sprite_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: sprite_row = 8'h3C;
      3'd1, 3'd6: sprite_row = 8'h7E;
      default:    sprite_row = 8'hFF;
    endcase
  endfunction

  logic [10:0] x_ext, y_ext;
  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  // Bounds are widened to 11 bits so sprites near the 1023 edge never wrap to low coordinates.
  logic [NUM_BALLS-1:0] ball_on_d;
  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    logic [10:0] bx, by;
    logic [2:0]  row, col;
    logic [7:0]  bits;
    logic        in_sq;
    assign bx    = {1'b0, ball_x[10*i +: 10]};
    assign by    = {1'b0, ball_y[10*i +: 10]};
    assign in_sq = (x_ext >= bx) && (x_ext <= bx + 11'd7) &&
                   (y_ext >= by) && (y_ext <= by + 11'd7);
    assign row   = y[2:0] - by[2:0];
    assign col   = x[2:0] - bx[2:0];
    assign bits  = sprite_row(row);
    assign ball_on_d[i] = ball_en[i] && in_sq && bits[col];
  end

  logic [10:0] p1_top, p1_bot, p2_top, p2_bot;
  logic        paddle1_on_d, paddle2_on_d;
  assign p1_top = {1'b0, paddle1_y} + TOP_M;
  assign p1_bot = p1_top + PAD_H;
  assign p2_top = {1'b0, paddle2_y} + TOP_M;
  assign p2_bot = p2_top + PAD_H;
  assign paddle1_on_d = (x >= 10'd32) && (x <= 10'd40) && (y_ext >= p1_top) && (y_ext <= p1_bot);
  assign paddle2_on_d = (x >= 10'd600) && (x <= 10'd608) && (y_ext >= p2_top) && (y_ext <= p2_bot);

  logic [IDX_W-1:0] win_idx_d;
  always_comb begin
    win_idx_d = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (ball_on_d[i]) win_idx_d = IDX_W'(i);
    end
  end

  // A hit reloads the counter even while it is still running; it never accumulates.
  logic [3:0] flash_cnt_l_d, flash_cnt_l_q, flash_cnt_r_d, flash_cnt_r_q;
  always_comb begin
    flash_cnt_l_d = flash_cnt_l_q;
    flash_cnt_r_d = flash_cnt_r_q;
    if (hit_l)                                 flash_cnt_l_d = FLASH_LOAD;
    else if (frame_tick && flash_cnt_l_q != 0) flash_cnt_l_d = flash_cnt_l_q - 4'd1;
    if (hit_r)                                 flash_cnt_r_d = FLASH_LOAD;
    else if (frame_tick && flash_cnt_r_q != 0) flash_cnt_r_d = flash_cnt_r_q - 4'd1;
  end

  logic                   video_on_q, text_on_q, game_over_q, paddle1_on_q, paddle2_on_q;
  logic [9:0]             x_q, y_q;
  logic [11:0]            text_rgb_q, bg_pixel_q, game_over_pixel_q, rgb_d, rgb_q;
  logic [NUM_BALLS-1:0]   ball_on_q;
  logic [IDX_W-1:0]       win_idx_q;
  logic [4*NUM_BALLS-1:0] ball_speed_q;
  logic [3:0]             win_speed;
  logic [11:0]            ball_rgb;

  always_comb begin
    win_speed = 4'd0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (win_idx_q == IDX_W'(i)) win_speed = ball_speed_q[4*i +: 4];
    end
    case (win_speed)
      4'd3:    ball_rgb = 12'h00F;
      4'd4:    ball_rgb = 12'h0F0;
      4'd5:    ball_rgb = 12'hF00;
      default: ball_rgb = 12'hFFF;
    endcase
    if (!video_on_q)                          rgb_d = 12'h000;
    else if (y_q < 10'(TOP_MARGIN))           rgb_d = text_on_q ? text_rgb_q : 12'h135;
    else if (x_q < 10'd32 || x_q > 10'd608)   rgb_d = 12'h89C;
    else if (game_over_q)                     rgb_d = game_over_pixel_q;
    else if (paddle1_on_q)                    rgb_d = (flash_cnt_l_q != 0) ? 12'hFFF : 12'h24F;
    else if (paddle2_on_q)                    rgb_d = (flash_cnt_r_q != 0) ? 12'hFFF : 12'h24F;
    else if (|ball_on_q)                      rgb_d = ball_rgb;
    else                                      rgb_d = bg_pixel_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      video_on_q        <= 1'b0;
      x_q               <= '0;
      y_q               <= '0;
      text_on_q         <= 1'b0;
      text_rgb_q        <= '0;
      bg_pixel_q        <= '0;
      game_over_pixel_q <= '0;
      game_over_q       <= 1'b0;
      ball_on_q         <= '0;
      win_idx_q         <= '0;
      ball_speed_q      <= '0;
      paddle1_on_q      <= 1'b0;
      paddle2_on_q      <= 1'b0;
      flash_cnt_l_q     <= '0;
      flash_cnt_r_q     <= '0;
      rgb_q             <= '0;
    end else begin
      video_on_q        <= video_on;
      x_q               <= x;
      y_q               <= y;
      text_on_q         <= text_on;
      text_rgb_q        <= text_rgb;
      bg_pixel_q        <= bg_pixel;
      game_over_pixel_q <= game_over_pixel;
      game_over_q       <= game_over;
      ball_on_q         <= ball_on_d;
      win_idx_q         <= win_idx_d;
      ball_speed_q      <= ball_speed;
      paddle1_on_q      <= paddle1_on_d;
      paddle2_on_q      <= paddle2_on_d;
      flash_cnt_l_q     <= flash_cnt_l_d;
      flash_cnt_r_q     <= flash_cnt_r_d;
      rgb_q             <= rgb_d;
    end
  end

  assign rgb = rgb_q;
endmodule

// File: doc/multi_ball_pixel_gen.md
# multi_ball_pixel_gen

Parametrised, pipelined successor to the pong pixel generator. Composites header text, walls, two paddles, up to NUM_BALLS round 8x8 ball sprites and the background/game-over images into one 12-bit RGB stream. Output is registered with fixed two-cycle latency from x/y. Adds per-ball enables, per-ball speed-coded colour and a frame-counted paddle hit-flash. Sits between the VGA sync/background ROMs and the VGA RGB pins.

## Interface
- NUM_BALLS, 4, number of ball sprites (1..8)
- TOP_MARGIN, 25, header height in lines
- PADDLE_H, 72, paddle height minus 1 (paddle spans PADDLE_H+1 lines)
- FLASH_FRAMES, 8, frames a paddle stays in flash colour after a hit (1..15)
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- video_on  in  1  active display region
- x, y  in  10 each  current pixel coordinate
- frame_tick  in  1  one-cycle pulse once per frame (start of vblank)
- text_on  in  1  header text pixel active
- text_rgb, bg_pixel, game_over_pixel  in  12 each  source pixels, aligned with x/y
- game_over  in  1  show game-over image in the playfield
- paddle1_y, paddle2_y  in  10 each  paddle top, playfield-relative
- ball_x, ball_y  in  10*NUM_BALLS each  flattened ball top-left; ball i at [10i+9:10i]
- ball_speed  in  4*NUM_BALLS  flattened speed per ball
- ball_en  in  NUM_BALLS  ball i drawn only when bit i = 1
- hit_l, hit_r  in  1 each  one-cycle pulse: ball struck left/right paddle
- rgb  out  12  registered pixel colour

## Operation
- Stage 1 (register): latch video_on, x, y, text_on, text_rgb, bg_pixel, game_over_pixel, game_over. Compute per-ball square-hit, sprite row = y[2:0]-ball_y[2:0], col = x[2:0]-ball_x[2:0] (3-bit, wraps mod 8), sprite bit. Latch ball_on[i] and winning ball index (lowest i with ball_on). Latch paddle1_on, paddle2_on.
- Sprite ROM rows 0..7: 3C,7E,FF,FF,FF,FF,7E,3C; bit index = col. Each ball has its own row lookup (no shared-ROM aliasing).
- All bound sums (ball+7, paddle_y+TOP_MARGIN+PADDLE_H) computed 11-bit; no wrap. Square hit: ball_x<=x<=ball_x+7 and ball_y<=y<=ball_y+7, inclusive.
- Stage 2 priority mux, first match wins: !video_on -> 000; y<TOP_MARGIN -> text_on ? text_rgb : 135; x<32 or x>608 -> 89C (wall); game_over -> game_over_pixel; paddle1 (32<=x<=40) -> flash_l ? FFF : 24F; paddle2 (600<=x<=608) -> flash_r ? FFF : 24F; any ball_on -> colour of winning ball; else bg_pixel.
- Ball colour by speed: 2 FFF, 3 00F, 4 0F0, 5 F00, any other FFF.
- Flash counters flash_cnt_l/r, 4 bits: hit pulse loads FLASH_FRAMES; else frame_tick with count>0 decrements; flash active while count != 0. Hit and frame_tick same cycle -> load wins. Hit while active -> reload (no accumulation). Counters run regardless of video_on/game_over.

## Timing
- Reset (rst_n=0 at clk edge): rgb=000, all stage-1 registers clear (video_on_q=0), flash counters 0. First valid pixel two cycles after reset release.
- Latency: inputs at edge N -> rgb at edge N+2; constant, no stalls, no handshake.
- Flash visible on the first pixel whose stage-2 evaluation follows the hit-load edge; lasts exactly FLASH_FRAMES frame_ticks.
- Reset mid-frame: counters and pipeline cleared same edge; stale pixels never emitted.

## Test plan
- Reset: hold rst_n=0 3 cycles with video_on=1 -> rgb=000; release, pixel (100,100) with bg_pixel=ABC -> rgb=ABC exactly 2 cycles later.
- Sprite shape: ball 0 at (200,200), speed 4, en=1 -> (203,200)=0F0, (200,200)=bg, (200,203)=0F0, (207,207)=bg, (208,203)=bg.
- Overlap/enable: balls 0,1 both at (300,300), speeds 5,3 -> F00; ball_en=2'b10 -> 00F; ball_en=0 -> bg; speed 9 -> FFF.
- Priority: y=10 with text_on=1, text_rgb=F0F -> F0F; x=20,y=100 -> 89C; game_over=1 on a ball pixel -> game_over_pixel; paddle1_y=0 at (36,25) -> 24F, (36,97) -> 24F, (36,98) -> bg.
- Flash: FLASH_FRAMES=3, hit_l pulse -> (36,50) FFF for 3 frame_ticks, 24F after third; hit_l coincident with frame_tick -> count=3; hit_l at count 1 -> reload to 3.
- Bounds: ball_x=1020 at x=1023 -> hit, no wrap to x=3; paddle2_y=1000 -> no false hit at low y.
